// File: rtl/pmp_csr_regfile.sv
// Machine-mode PMP CSR register file: pmpcfg/pmpaddr storage with lock and WARL rules.
// conf_o packs one byte per entry in CSR layout {L, 2'b00, A[1:0], X, W, R}; reserved bits are always 0.
module pmp_csr_regfile #(
   parameter int unsigned NrPMPEntries = 16,
   parameter int unsigned PLEN         = 34,
   parameter int unsigned XLEN         = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             csr_valid_i,
   output logic                             csr_ready_o,
   input  logic                             csr_we_i,
   input  logic [11:0]                      csr_addr_i,
   input  logic [XLEN-1:0]                  csr_wdata_i,
   output logic                             csr_rvalid_o,
   output logic [XLEN-1:0]                  csr_rdata_o,
   output logic                             csr_err_o,
   output logic [NrPMPEntries*(PLEN-2)-1:0] conf_addr_o,
   output logic [NrPMPEntries*8-1:0]        conf_o,
   output logic                             pmp_update_o
);
   localparam int unsigned AW    = PLEN - 2;
   localparam logic [1:0]  A_TOR = 2'b01;

   typedef enum logic {IDLE, RESP} state_e;

   state_e          state_q, state_d;
   logic [7:0]      cfg_q  [NrPMPEntries];
   logic [7:0]      cfg_d  [NrPMPEntries];
   logic [AW-1:0]   addr_q [NrPMPEntries];
   logic [AW-1:0]   addr_d [NrPMPEntries];
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            upd_q, upd_d;

   logic [NrPMPEntries-1:0] tor_lock;
   logic                    accept;
   logic                    is_cfg;
   logic                    is_addr;
   logic [5:0]              addr_idx;
   logic [3:0]              cfg_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NrPMPEntries; gi++) begin : g_entry
         // A locked TOR entry also freezes the pmpaddr below it, which is that entry's base
         if (gi + 1 < NrPMPEntries) begin : g_tor
            assign tor_lock[gi] = cfg_q[gi+1][7] && (cfg_q[gi+1][4:3] == A_TOR);
         end else begin : g_last
            assign tor_lock[gi] = 1'b0;
         end
         assign conf_o[gi*8 +: 8]       = cfg_q[gi];
         assign conf_addr_o[gi*AW +: AW] = addr_q[gi];
      end
   endgenerate

   assign accept   = csr_valid_i && (state_q == IDLE);
   assign is_cfg   = (csr_addr_i[11:4] == 8'h3A);
   assign is_addr  = (csr_addr_i >= 12'h3B0) && (csr_addr_i <= 12'h3EF);
   assign addr_idx = 6'(csr_addr_i - 12'h3B0);
   assign cfg_idx  = csr_addr_i[3:0];

   always_comb begin
      logic [7:0] wbyte;
      logic [7:0] cfg_new;
      state_d = state_q;
      cfg_d   = cfg_q;
      addr_d  = addr_q;
      rdata_d = '0;
      err_d   = 1'b0;
      upd_d   = 1'b0;
      wbyte   = '0;
      cfg_new = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RESP;
               err_d   = !(is_cfg || is_addr);
               for (int i = 0; i < int'(NrPMPEntries); i++) begin
                  if (is_cfg && ((i / 4) == int'(cfg_idx))) begin
                     rdata_d[(i%4)*8 +: 8] = cfg_q[i];
                     wbyte   = csr_wdata_i[(i%4)*8 +: 8];
                     // Drop reserved bits and fold the illegal W-without-R combination to W=0
                     cfg_new    = wbyte & 8'h9F;
                     cfg_new[1] = wbyte[1] & wbyte[0];
                     if (csr_we_i && !cfg_q[i][7]) begin
                        cfg_d[i] = cfg_new;
                        if (cfg_new != cfg_q[i]) upd_d = 1'b1;
                     end
                  end
                  if (is_addr && (i == int'(addr_idx))) begin
                     rdata_d = XLEN'(addr_q[i]);
                     if (csr_we_i && !cfg_q[i][7] && !tor_lock[i]) begin
                        addr_d[i] = csr_wdata_i[AW-1:0];
                        if (csr_wdata_i[AW-1:0] != addr_q[i]) upd_d = 1'b1;
                     end
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         upd_q   <= 1'b0;
         for (int i = 0; i < int'(NrPMPEntries); i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         upd_q   <= upd_d;
         cfg_q   <= cfg_d;
         addr_q  <= addr_d;
      end
   end

   assign csr_ready_o  = (state_q == IDLE);
   assign csr_rvalid_o = (state_q == RESP);
   assign csr_rdata_o  = rdata_q;
   assign csr_err_o    = err_q;
   assign pmp_update_o = upd_q;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Scoreboard bench for pmp_csr_regfile: directed scenarios plus random CSR traffic
// checked against a rule-level model of the PMP CSR state.
module tb_pmp_csr_regfile;
   localparam int NE   = 16;
   localparam int PLEN = 34;
   localparam int XLEN = 32;
   localparam int AW   = PLEN - 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              csr_valid = 1'b0;
   logic              csr_ready;
   logic              csr_we = 1'b0;
   logic [11:0]       csr_addr = '0;
   logic [XLEN-1:0]   csr_wdata = '0;
   logic              csr_rvalid;
   logic [XLEN-1:0]   csr_rdata;
   logic              csr_err;
   logic [NE*AW-1:0]  conf_addr;
   logic [NE*8-1:0]   conf;
   logic              pmp_update;

   pmp_csr_regfile #(.NrPMPEntries(NE), .PLEN(PLEN), .XLEN(XLEN)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .csr_valid_i  (csr_valid),
      .csr_ready_o  (csr_ready),
      .csr_we_i     (csr_we),
      .csr_addr_i   (csr_addr),
      .csr_wdata_i  (csr_wdata),
      .csr_rvalid_o (csr_rvalid),
      .csr_rdata_o  (csr_rdata),
      .csr_err_o    (csr_err),
      .conf_addr_o  (conf_addr),
      .conf_o       (conf),
      .pmp_update_o (pmp_update)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]      rdata;
      logic             err;
      logic             upd;
      logic [NE*8-1:0]  conf;
      logic [NE*AW-1:0] caddr;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  cfg_m  [NE];
   logic [AW-1:0] addr_m [NE];
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NE; i++) begin
         cfg_m[i]  = '0;
         addr_m[i] = '0;
      end
   endfunction

   // Applies one CSR access to the model and returns the response plus the resulting config state
   function automatic exp_t model_access(input bit we, input logic [11:0] a, input logic [31:0] wd);
      exp_t       e;
      int         idx;
      bit         lk;
      logic [7:0] nb;
      e = '0;
      if (a >= 12'h3A0 && a <= 12'h3AF) begin
         for (int k = 0; k < 4; k++) begin
            idx = (int'(a) - 'h3A0) * 4 + k;
            if (idx < NE) begin
               e.rdata[k*8 +: 8] = cfg_m[idx];
               if (we && !cfg_m[idx][7]) begin
                  nb = wd[k*8 +: 8];
                  nb[6:5] = 2'b00;
                  if (!nb[0]) nb[1] = 1'b0;
                  if (nb != cfg_m[idx]) e.upd = 1'b1;
                  cfg_m[idx] = nb;
               end
            end
         end
      end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
         idx = int'(a) - 'h3B0;
         if (idx < NE) begin
            e.rdata = 32'(addr_m[idx]);
            lk = cfg_m[idx][7];
            if (idx + 1 < NE) lk = lk || (cfg_m[idx+1][7] && cfg_m[idx+1][4:3] == 2'b01);
            if (we && !lk) begin
               if (wd[AW-1:0] != addr_m[idx]) e.upd = 1'b1;
               addr_m[idx] = wd[AW-1:0];
            end
         end
      end else begin
         e.err = 1'b1;
      end
      for (int i = 0; i < NE; i++) begin
         e.conf[i*8 +: 8]   = cfg_m[i];
         e.caddr[i*AW +: AW] = addr_m[i];
      end
      return e;
   endfunction

   // Called just after a falling edge; returns just after the falling edge of the response cycle
   task automatic req(input bit we, input logic [11:0] a, input logic [31:0] wd);
      int n = 0;
      csr_valid = 1'b1;
      csr_we    = we;
      csr_addr  = a;
      csr_wdata = wd;
      while (!csr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!csr_ready) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout actual=0 required=1");
         csr_valid = 1'b0;
         return;
      end
      exp_q.push_back(model_access(we, a, wd));
      @(posedge clk);
      @(negedge clk);
      csr_valid = 1'b0;
      $display("txn we=%0d addr=%h wdata=%h", we, a, wd);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (csr_rvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rvalid actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               check("rdata", 512'(csr_rdata), 512'(e.rdata));
               check("err", 512'(csr_err), 512'(e.err));
               check("update", 512'(pmp_update), 512'(e.upd));
               check("conf", 512'(conf), 512'(e.conf));
               check("conf_addr", 512'(conf_addr), 512'(e.caddr));
            end
         end else if (pmp_update) begin
            checks++;
            failures++;
            $display("FAIL update_outside_resp actual=1 required=0");
         end
      end
   end

   initial begin : stim
      logic [11:0] a;
      logic [31:0] wd;
      int          r;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      check("reset_ready", 512'(csr_ready), 512'(1));
      check("reset_rvalid", 512'(csr_rvalid), 512'(0));
      check("reset_err", 512'(csr_err), 512'(0));
      check("reset_rdata", 512'(csr_rdata), 512'(0));
      check("reset_conf", 512'(conf), 512'(0));
      check("reset_conf_addr", 512'(conf_addr), 512'(0));

      req(1'b0, 12'h3A0, 32'h0);
      req(1'b0, 12'h3B5, 32'h0);

      req(1'b1, 12'h3B0, 32'h2000_0000);
      req(1'b1, 12'h3A0, 32'h0000_000F);
      check("entry0_addr", 512'(conf_addr[AW-1:0]), 512'(32'h2000_0000));
      check("entry0_cfg_tor_xwr", 512'(conf[7:0]), 512'(8'h0F));

      req(1'b1, 12'h3A0, 32'h0000_0002);
      check("entry0_warl_w_only", 512'(conf[7:0]), 512'(8'h00));
      req(1'b0, 12'h3A0, 32'h0);
      req(1'b1, 12'h3A0, 32'h0000_0002);

      req(1'b1, 12'h3A0, 32'h0000_8F00);
      req(1'b1, 12'h3B0, 32'h0000_1234);
      req(1'b1, 12'h3A0, 32'h0000_0000);
      req(1'b0, 12'h3A0, 32'h0);
      check("tor_locked_addr0", 512'(conf_addr[AW-1:0]), 512'(32'h2000_0000));
      check("locked_entry1", 512'(conf[15:8]), 512'(8'h8F));

      req(1'b0, 12'h3C5, 32'h0);
      req(1'b1, 12'h3C5, 32'hFFFF_FFFF);
      req(1'b1, 12'h7A0, 32'hFFFF_FFFF);
      req(1'b0, 12'h7A0, 32'h0);

      // Reset asserted while the write to pmpaddr2 is in its response cycle
      @(negedge clk);
      csr_valid = 1'b1;
      csr_we    = 1'b1;
      csr_addr  = 12'h3B2;
      csr_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      csr_valid = 1'b0;
      $display("txn we=1 addr=3b2 wdata=deadbeef (reset during response)");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check("midreset_conf_addr2", 512'(conf_addr[2*AW +: AW]), 512'(0));
      check("midreset_ready", 512'(csr_ready), 512'(1));
      check("midreset_rvalid", 512'(csr_rvalid), 512'(0));
      check("midreset_conf", 512'(conf), 512'(0));

      for (int i = 0; i < 300; i++) begin
         if (i == 150) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
         end
         r = $urandom_range(0, 9);
         if (r < 4) a = 12'h3A0 + 12'($urandom_range(0, 4));
         else if (r < 9) a = 12'h3B0 + 12'($urandom_range(0, 20));
         else a = 12'($urandom_range(0, 4095));
         wd = $urandom;
         if ($urandom_range(0, 7) != 0) wd = wd & 32'h7F7F_7F7F;
         req(1'($urandom_range(0, 1)), a, wd);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 512'(exp_q.size()), 512'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
